regfile_wr_arbiter: RTL and testbench
=====================================

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 Parameter: PRIO_MODE, default 0; 0 = round-robin between ports A and B, 1 = fixed priority to port A.
REQ-002 Clocking: one clock, CLK; reset is asynchronous and active-low, reset_n.
REQ-003 CLK  input  1  rising-edge clock, same clock as the register file.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 a_valid  input  1  port A (ALU writeback) write request.
REQ-006 a_addr  input  4  port A destination register.
REQ-007 a_data  input  32  port A write data.
REQ-008 a_ready  output  1  port A request accepted this edge when a_valid & a_ready.
REQ-009 b_valid, b_addr[3:0], b_data[31:0], b_ready: port B (load writeback), same meaning as port A.
REQ-010 flush  input  1  synchronous discard of all held requests.
REQ-011 chk_a1, chk_a2  input  4 each  register-file read addresses to check for pending writes.
REQ-012 hazard  output  1  a read address matches a pending write.
REQ-013 WE3  output  1  register-file write enable.
REQ-014 A3  output  4  register-file write address.
REQ-015 WD3  output  32  register-file write data.
REQ-016 err_r15  output  1  one-cycle pulse: a write to register 15 was dropped.

Function
REQ-017 Each port SHALL have a one-entry holding register with state EMPTY or FULL.
REQ-018 Handshake: x_ready SHALL be 1 when that holding register is EMPTY, or FULL and granted this cycle, and flush is 0.
REQ-019 On an accepting edge (x_valid & x_ready) with x_addr != 15, addr and data SHALL load into the holding register, which becomes FULL.
REQ-020 An accepted request with x_addr == 15 SHALL NOT be buffered or written.
REQ-021 For such a request, err_r15 SHALL be 1 for exactly the following cycle; simultaneous A and B R15 writes give one pulse.
REQ-022 Grant: when only one holding register is FULL it SHALL be granted; when both are FULL, the PRIO_MODE rule applies.
REQ-023 Round-robin SHALL grant the port not granted most recently; the last-grant flop resets to B, so A wins the first tie.
REQ-024 WE3 SHALL be 1 exactly when a grant exists; A3/WD3 SHALL equal the granted entry, combinationally from flops only.
REQ-025 A3/WD3 SHALL be 0 when WE3 = 0.
REQ-026 The granted entry SHALL return to EMPTY at the edge, unless refilled by a same-edge acceptance.
REQ-027 Latency: request accepted at edge N SHALL drive WE3 in cycle N..N+1 and commit at edge N+1 when uncontested; the loser waits exactly one extra cycle.
REQ-028 Throughput: one write per cycle; combined A+B sustained input SHALL be served alternately under round-robin without loss.
REQ-029 Same address held in A and B: writes SHALL commit in grant order, with no merging.
REQ-030 hazard SHALL be 1 when chk_a1 or chk_a2 equals the addr of any FULL entry; purely combinational from flops and chk inputs.
REQ-031 flush = 1: both entries SHALL go EMPTY at the edge, WE3 SHALL be 0 that cycle, and no request SHALL be accepted.
REQ-032 PRIO_MODE = 1: A SHALL always win ties; B MAY starve, and this is not an error.

Reset
REQ-033 reset_n low SHALL asynchronously clear both entries to EMPTY, last-grant to B, and err_r15 to 0.
REQ-034 During reset: WE3 = 0, A3 = 0, WD3 = 0, hazard = 0, a_ready = b_ready = 0.
REQ-035 Reset asserted mid-operation SHALL discard held writes; none SHALL reach WE3 after reset_n falls.
REQ-036 Ready SHALL rise in the first cycle after reset_n is sampled high.

Verification
REQ-037 Single write: A writes addr 3, data 0x12345678 -> next cycle WE3 = 1, A3 = 3, WD3 = 0x12345678, hazard = 1 for chk_a1 = 3; then idle.
REQ-038 Tie, round-robin: A (r1, 0xA) and B (r2, 0xB) on the same edge -> r1 writes, then r2; repeat -> B then A alternates.
REQ-039 Back-to-back: A valid every cycle with addr 0..14 -> a_ready stays 1 and 15 consecutive WE3 cycles occur in order.
REQ-040 R15 drop: B writes addr 15 -> WE3 stays 0 and err_r15 pulses one cycle; an A write in the same cycle is still performed.
REQ-041 Flush and reset: two FULL entries then flush -> no WE3 and hazard = 0; repeat with async reset_n mid-cycle -> outputs 0 immediately.
REQ-042 PRIO_MODE = 1 with A and B continuously valid -> only A writes and b_ready stays 0 after the first B acceptance.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// Two-port write arbiter in front of a single-write-port register file.
// Each port has a one-entry holding register; R15 writes are dropped and flagged.
module regfile_wr_arbiter #(
  parameter int PRIO_MODE = 0
) (
  input  logic        CLK,
  input  logic        reset_n,
  input  logic        a_valid,
  input  logic [3:0]  a_addr,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [3:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        b_ready,
  input  logic        flush,
  input  logic [3:0]  chk_a1,
  input  logic [3:0]  chk_a2,
  output logic        hazard,
  output logic        WE3,
  output logic [3:0]  A3,
  output logic [31:0] WD3,
  output logic        err_r15
);

  // state | meaning
  // EMPTY | holding register free, port may accept
  // FULL  | holding register owns a pending write
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} ent_state_t;

  ent_state_t  a_state, a_state_nxt;
  ent_state_t  b_state, b_state_nxt;
  logic [3:0]  a_addr_q, a_addr_nxt, b_addr_q, b_addr_nxt;
  logic [31:0] a_data_q, a_data_nxt, b_data_q, b_data_nxt;
  logic        last_b, last_b_nxt;
  logic        rst_done;
  logic        err_nxt;
  logic        a_full, b_full, tie_a;
  logic        gnt_a, gnt_b;
  logic        acc_a, acc_b;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      a_state  <= EMPTY;
      b_state  <= EMPTY;
      a_addr_q <= '0;
      b_addr_q <= '0;
      a_data_q <= '0;
      b_data_q <= '0;
      last_b   <= 1'b1;
      err_r15  <= 1'b0;
      rst_done <= 1'b0;
    end else begin
      a_state  <= a_state_nxt;
      b_state  <= b_state_nxt;
      a_addr_q <= a_addr_nxt;
      b_addr_q <= b_addr_nxt;
      a_data_q <= a_data_nxt;
      b_data_q <= b_data_nxt;
      last_b   <= last_b_nxt;
      err_r15  <= err_nxt;
      rst_done <= 1'b1;
    end
  end

  // A refill on the same edge as the grant wins over the drain
  always_comb begin
    a_state_nxt = a_state;
    a_addr_nxt  = a_addr_q;
    a_data_nxt  = a_data_q;
    if (flush) begin
      a_state_nxt = EMPTY;
    end else if (acc_a && (a_addr != 4'hF)) begin
      a_state_nxt = FULL;
      a_addr_nxt  = a_addr;
      a_data_nxt  = a_data;
    end else if (gnt_a) begin
      a_state_nxt = EMPTY;
    end

    b_state_nxt = b_state;
    b_addr_nxt  = b_addr_q;
    b_data_nxt  = b_data_q;
    if (flush) begin
      b_state_nxt = EMPTY;
    end else if (acc_b && (b_addr != 4'hF)) begin
      b_state_nxt = FULL;
      b_addr_nxt  = b_addr;
      b_data_nxt  = b_data;
    end else if (gnt_b) begin
      b_state_nxt = EMPTY;
    end

    last_b_nxt = last_b;
    if (gnt_a) begin
      last_b_nxt = 1'b0;
    end else if (gnt_b) begin
      last_b_nxt = 1'b1;
    end

    err_nxt = (acc_a && (a_addr == 4'hF)) || (acc_b && (b_addr == 4'hF));
  end

  always_comb begin
    a_full  = (a_state == FULL);
    b_full  = (b_state == FULL);
    tie_a   = (PRIO_MODE != 0) ? 1'b1 : last_b;
    gnt_a   = !flush && a_full && (!b_full || tie_a);
    gnt_b   = !flush && b_full && (!a_full || !tie_a);
    a_ready = rst_done && !flush && (!a_full || gnt_a);
    b_ready = rst_done && !flush && (!b_full || gnt_b);
    acc_a   = a_valid && a_ready;
    acc_b   = b_valid && b_ready;
    WE3     = gnt_a || gnt_b;
    A3      = '0;
    WD3     = '0;
    if (gnt_a) begin
      A3  = a_addr_q;
      WD3 = a_data_q;
    end else if (gnt_b) begin
      A3  = b_addr_q;
      WD3 = b_data_q;
    end
    hazard = (a_full && ((chk_a1 == a_addr_q) || (chk_a2 == a_addr_q))) ||
             (b_full && ((chk_a1 == b_addr_q) || (chk_a2 == b_addr_q)));
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: round-robin instance plus a fixed-priority instance.
module tb_regfile_wr_arbiter;

  logic        CLK = 1'b0;
  logic        reset_n;
  logic        a_valid, b_valid, flush;
  logic [3:0]  a_addr, b_addr, chk_a1, chk_a2;
  logic [31:0] a_data, b_data;

  logic        a_ready, b_ready, hazard, WE3, err_r15;
  logic [3:0]  A3;
  logic [31:0] WD3;
  logic        p_a_ready, p_b_ready, p_hazard, p_WE3, p_err_r15;
  logic [3:0]  p_A3;
  logic [31:0] p_WD3;

  int n_chk = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  regfile_wr_arbiter #(.PRIO_MODE(0)) dut (
    .CLK(CLK), .reset_n(reset_n),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .flush(flush), .chk_a1(chk_a1), .chk_a2(chk_a2), .hazard(hazard),
    .WE3(WE3), .A3(A3), .WD3(WD3), .err_r15(err_r15)
  );

  regfile_wr_arbiter #(.PRIO_MODE(1)) dut_p (
    .CLK(CLK), .reset_n(reset_n),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(p_a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(p_b_ready),
    .flush(flush), .chk_a1(chk_a1), .chk_a2(chk_a2), .hazard(p_hazard),
    .WE3(p_WE3), .A3(p_A3), .WD3(p_WD3), .err_r15(p_err_r15)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    flush = 1'b0; chk_a1 = '0; chk_a2 = '0;

    #2;
    check_val("rst_we3", 32'(WE3), 32'd0);
    check_val("rst_a3", 32'(A3), 32'd0);
    check_val("rst_wd3", WD3, 32'd0);
    check_val("rst_hazard", 32'(hazard), 32'd0);
    check_val("rst_a_ready", 32'(a_ready), 32'd0);
    check_val("rst_b_ready", 32'(b_ready), 32'd0);
    check_val("rst_err", 32'(err_r15), 32'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    reset_n = 1'b1;
    #1;
    check_val("pre_rise_ready", 32'(a_ready), 32'd0);
    tick();
    check_val("post_rst_a_ready", 32'(a_ready), 32'd1);
    check_val("post_rst_b_ready", 32'(b_ready), 32'd1);

    // tie after reset: A first, then B wins the next tie against a refilled A
    a_valid = 1'b1; a_addr = 4'd1; a_data = 32'hA;
    b_valid = 1'b1; b_addr = 4'd2; b_data = 32'hB;
    #1;
    check_val("tie_a_ready", 32'(a_ready), 32'd1);
    check_val("tie_b_ready", 32'(b_ready), 32'd1);
    check_val("tie_we3_idle", 32'(WE3), 32'd0);
    tick();
    a_addr = 4'd5; a_data = 32'hA5; b_valid = 1'b0;
    #1;
    check_val("tie1_we3", 32'(WE3), 32'd1);
    check_val("tie1_a3", 32'(A3), 32'd1);
    check_val("tie1_wd3", WD3, 32'hA);
    check_val("tie1_a_ready", 32'(a_ready), 32'd1);
    check_val("tie1_b_ready", 32'(b_ready), 32'd0);
    tick();
    a_valid = 1'b0;
    #1;
    check_val("tie2_a3", 32'(A3), 32'd2);
    check_val("tie2_wd3", WD3, 32'hB);
    check_val("tie2_a_ready", 32'(a_ready), 32'd0);
    tick();
    check_val("tie3_we3", 32'(WE3), 32'd1);
    check_val("tie3_a3", 32'(A3), 32'd5);
    check_val("tie3_wd3", WD3, 32'hA5);
    tick();
    check_val("tie_end_we3", 32'(WE3), 32'd0);
    check_val("tie_end_a3", 32'(A3), 32'd0);
    check_val("tie_end_wd3", WD3, 32'd0);

    // single write with hazard
    a_valid = 1'b1; a_addr = 4'd3; a_data = 32'h12345678;
    #1;
    check_val("sw_a_ready", 32'(a_ready), 32'd1);
    tick();
    a_valid = 1'b0; chk_a1 = 4'd3;
    #1;
    check_val("sw_we3", 32'(WE3), 32'd1);
    check_val("sw_a3", 32'(A3), 32'd3);
    check_val("sw_wd3", WD3, 32'h12345678);
    check_val("sw_hazard", 32'(hazard), 32'd1);
    chk_a1 = 4'd4;
    #1;
    check_val("sw_no_hazard", 32'(hazard), 32'd0);
    chk_a1 = 4'd3;
    tick();
    check_val("sw_idle_we3", 32'(WE3), 32'd0);
    check_val("sw_idle_hazard", 32'(hazard), 32'd0);

    // back-to-back on A, addr 0..14
    for (int i = 0; i < 15; i++) begin
      a_valid = 1'b1; a_addr = 4'(i); a_data = 32'h100 + 32'(i);
      #1;
      check_val("b2b_a_ready", 32'(a_ready), 32'd1);
      if (i == 0) begin
        check_val("b2b_first_we3", 32'(WE3), 32'd0);
      end else begin
        check_val("b2b_we3", 32'(WE3), 32'd1);
        check_val("b2b_a3", 32'(A3), 32'(i - 1));
        check_val("b2b_wd3", WD3, 32'h100 + 32'(i - 1));
      end
      tick();
    end
    a_valid = 1'b0;
    #1;
    check_val("b2b_last_we3", 32'(WE3), 32'd1);
    check_val("b2b_last_a3", 32'(A3), 32'd14);
    tick();
    check_val("b2b_done_we3", 32'(WE3), 32'd0);

    // R15 drop on B alongside a real A write
    a_valid = 1'b1; a_addr = 4'd7; a_data = 32'h77;
    b_valid = 1'b1; b_addr = 4'd15; b_data = 32'hDEAD;
    #1;
    check_val("r15_b_ready", 32'(b_ready), 32'd1);
    check_val("r15_err_pre", 32'(err_r15), 32'd0);
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    #1;
    check_val("r15_err", 32'(err_r15), 32'd1);
    check_val("r15_we3", 32'(WE3), 32'd1);
    check_val("r15_a3", 32'(A3), 32'd7);
    check_val("r15_wd3", WD3, 32'h77);
    check_val("r15_b_empty", 32'(b_ready), 32'd1);
    tick();
    check_val("r15_err_off", 32'(err_r15), 32'd0);
    check_val("r15_we3_off", 32'(WE3), 32'd0);
    a_valid = 1'b1; a_addr = 4'd15; b_valid = 1'b1; b_addr = 4'd15;
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    #1;
    check_val("r15x2_err", 32'(err_r15), 32'd1);
    check_val("r15x2_we3", 32'(WE3), 32'd0);
    tick();
    check_val("r15x2_err_off", 32'(err_r15), 32'd0);

    // flush with both entries full
    a_valid = 1'b1; a_addr = 4'd4; a_data = 32'h44;
    b_valid = 1'b1; b_addr = 4'd6; b_data = 32'h66;
    tick();
    b_valid = 1'b0; flush = 1'b1; chk_a1 = 4'd4; chk_a2 = 4'd6;
    a_addr = 4'd9; a_data = 32'h99;
    #1;
    check_val("fl_we3", 32'(WE3), 32'd0);
    check_val("fl_a3", 32'(A3), 32'd0);
    check_val("fl_a_ready", 32'(a_ready), 32'd0);
    check_val("fl_b_ready", 32'(b_ready), 32'd0);
    check_val("fl_hazard_held", 32'(hazard), 32'd1);
    tick();
    flush = 1'b0; a_valid = 1'b0; chk_a1 = 4'd9;
    #1;
    check_val("fl_after_hazard", 32'(hazard), 32'd0);
    check_val("fl_after_we3", 32'(WE3), 32'd0);
    tick();
    check_val("fl_after2_we3", 32'(WE3), 32'd0);

    // async reset mid-cycle with both entries full
    a_valid = 1'b1; a_addr = 4'd10; a_data = 32'hAA;
    b_valid = 1'b1; b_addr = 4'd11; b_data = 32'hBB;
    tick();
    a_valid = 1'b0; b_valid = 1'b0; chk_a1 = 4'd10; chk_a2 = 4'd11;
    #1;
    check_val("ar_pre_we3", 32'(WE3), 32'd1);
    check_val("ar_pre_hazard", 32'(hazard), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("ar_we3", 32'(WE3), 32'd0);
    check_val("ar_a3", 32'(A3), 32'd0);
    check_val("ar_wd3", WD3, 32'd0);
    check_val("ar_hazard", 32'(hazard), 32'd0);
    check_val("ar_a_ready", 32'(a_ready), 32'd0);
    check_val("ar_b_ready", 32'(b_ready), 32'd0);
    tick();
    tick();
    @(negedge CLK);
    reset_n = 1'b1;
    tick();
    check_val("ar_post_we3", 32'(WE3), 32'd0);
    check_val("ar_post_hazard", 32'(hazard), 32'd0);
    check_val("ar_post_a_ready", 32'(a_ready), 32'd1);
    check_val("ar_post_p_we3", 32'(p_WE3), 32'd0);

    // fixed priority: A always wins, B starves after its first acceptance
    a_valid = 1'b1; b_valid = 1'b1; b_addr = 4'd8; b_data = 32'h88;
    for (int i = 0; i < 6; i++) begin
      a_addr = 4'(i); a_data = 32'h200 + 32'(i);
      #1;
      if (i == 0) begin
        check_val("pr_first_a_ready", 32'(p_a_ready), 32'd1);
        check_val("pr_first_b_ready", 32'(p_b_ready), 32'd1);
        check_val("pr_first_we3", 32'(p_WE3), 32'd0);
      end else begin
        check_val("pr_we3", 32'(p_WE3), 32'd1);
        check_val("pr_a3", 32'(p_A3), 32'(i - 1));
        check_val("pr_wd3", p_WD3, 32'h200 + 32'(i - 1));
        check_val("pr_a_ready", 32'(p_a_ready), 32'd1);
        check_val("pr_b_ready", 32'(p_b_ready), 32'd0);
      end
      tick();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
